// File: rtl/audio_stream_writer.sv
// Avalon-MM slave that accepts audio samples from the CPU and plays them out
// through a valid/ready source, buffered by a DEPTH-entry FIFO and one output register.
module audio_stream_writer #(
    parameter int DATA_SIZE = 24,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          read_data,
    output logic                 sink_valid,
    output logic [DATA_SIZE-1:0] sink_data,
    input  logic                 sink_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_UCOUNT = 2'd2;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     push_addr;
    logic [LVL_W-1:0]     level;
    logic                 enable;
    logic                 overflow;
    logic                 underrun;
    logic [CNT_W-1:0]     underrun_cnt;

    logic bus_wr;
    logic bus_rd;
    logic data_wr;
    logic ctrl_wr;
    logic cnt_wr;
    logic flush;
    logic clr_flags;
    logic full;
    logic empty;
    logic push;
    logic load;
    logic ovf_set;
    logic ur_event;
    logic [31:0] status;
    logic [31:0] rd_mux;

    // Only writedata[DATA_SIZE-1:0] and CTRL bits 2:0 carry meaning.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign bus_wr    = chipselect && write;
    assign bus_rd    = chipselect && read;
    assign data_wr   = bus_wr && (address == ADDR_DATA);
    assign ctrl_wr   = bus_wr && (address == ADDR_CTRL);
    assign cnt_wr    = bus_wr && (address == ADDR_UCOUNT);
    assign flush     = ctrl_wr && writedata[1];
    assign clr_flags = ctrl_wr && writedata[2];

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // A flush frees the whole FIFO first, so a push in the same cycle always lands.
    assign push     = data_wr && (flush || !full);
    assign ovf_set  = data_wr && full && !flush;
    assign load     = enable && !empty && (!sink_valid || sink_ready) && !flush;
    assign ur_event = enable && sink_ready && !sink_valid && empty;

    assign push_addr = flush ? '0 : wr_ptr;

    assign status = {16'(level), 11'd0, enable, underrun, overflow, full, empty};

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:   rd_mux = status;
            ADDR_UCOUNT: rd_mux = 32'(underrun_cnt);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_addr] <= writedata[DATA_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(push);
            level  <= LVL_W'(push);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, load})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Output register: a presented sample is only retracted by acceptance, flush or reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sink_valid <= 1'b0;
            sink_data  <= '0;
        end else if (flush) begin
            sink_valid <= 1'b0;
        end else if (load) begin
            sink_valid <= 1'b1;
            sink_data  <= mem[rd_ptr];
        end else if (sink_valid && sink_ready) begin
            sink_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable       <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= writedata[0];
            end
            if (clr_flags) begin
                overflow <= 1'b0;
                underrun <= 1'b0;
            end else begin
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
                if (ur_event) begin
                    underrun <= 1'b1;
                end
            end
            if (cnt_wr) begin
                underrun_cnt <= '0;
            end else if (ur_event && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end
        end
    end

    // Reads sample the register file before any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_data <= '0;
        end else if (bus_rd) begin
            read_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_audio_stream_writer.sv
// Self-checking bench for audio_stream_writer: scenario tasks plus randomized
// traffic compared against a queue-based reference model.
module tb_audio_stream_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] read_data;
    logic        sink_valid;
    logic [23:0] sink_data;
    logic        sink_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [23:0] q[$];
    bit          m_valid;
    logic [23:0] m_data;
    bit          m_en;
    bit          m_ovf;
    bit          m_und;
    int          m_cnt;
    logic [31:0] m_rd;

    audio_stream_writer #(
        .DATA_SIZE(24),
        .DEPTH(16),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .read_data(read_data),
        .sink_valid(sink_valid),
        .sink_data(sink_data),
        .sink_ready(sink_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_status();
        int n;
        n = q.size();
        return {16'(n), 11'd0, m_en, m_und, m_ovf, (n == 16), (n == 0)};
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        bit wr;
        bit rd;
        bit full0;
        bit empty0;
        bit ev;
        if (!reset_n) begin
            q.delete();
            m_valid = 0;
            m_data  = '0;
            m_en    = 0;
            m_ovf   = 0;
            m_und   = 0;
            m_cnt   = 0;
            m_rd    = '0;
            return;
        end
        wr = chipselect && write;
        rd = chipselect && read;
        if (rd) begin
            m_rd = (address == 2'd1) ? model_status() :
                   (address == 2'd2) ? 32'(m_cnt) : 32'd0;
        end
        full0  = (q.size() == 16);
        empty0 = (q.size() == 0);
        ev     = m_en && sink_ready && !m_valid && empty0;
        if (wr && address == 2'd1 && writedata[1]) begin
            q.delete();
            m_valid = 0;
        end else if (m_en && !empty0 && (!m_valid || sink_ready)) begin
            m_data  = q.pop_front();
            m_valid = 1;
        end else if (m_valid && sink_ready) begin
            m_valid = 0;
        end
        if (wr && address == 2'd0) begin
            if (full0) m_ovf = 1;
            else q.push_back(writedata[23:0]);
        end
        if (ev) begin
            m_und = 1;
            if (m_cnt < 15) m_cnt++;
        end
        if (wr && address == 2'd1) begin
            m_en = writedata[0];
            if (writedata[2]) begin
                m_ovf = 0;
                m_und = 0;
            end
        end
        if (wr && address == 2'd2) m_cnt = 0;
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = a;
        writedata  = d;
        cycle();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
        cycle();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        checks++; if (read_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_read_data got=%h exp=%h", read_data, 32'd0); end
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sink_valid got=%b exp=0", sink_valid); end
        checks++; if (sink_data !== 24'd0) begin errors++; $display("[TB] FAIL reset_sink_data got=%h exp=0", sink_data); end
        reset_n = 1'b1;
        bus_read(2'd1);
        checks++; if (read_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL reset_status got=%h exp=%h", read_data, 32'h1); end
    endtask

    task automatic test_single();
        sink_ready = 1'b1;
        bus_write(2'd1, 32'h1);
        bus_write(2'd0, 32'h0012_3456);
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency got=%b exp=0", sink_valid); end
        cycle();
        checks++; if (sink_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%b exp=1", sink_valid); end
        checks++; if (sink_data !== 24'h123456) begin errors++; $display("[TB] FAIL single_data got=%h exp=123456", sink_data); end
        cycle();
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_done got=%b exp=0", sink_valid); end
        bus_read(2'd1);
        checks++; if (read_data[4] !== 1'b1 || read_data[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_status_bits got=%h exp en=1 empty=1", read_data); end
        checks++; if (read_data !== m_rd) begin errors++; $display("[TB] FAIL single_status got=%h exp=%h", read_data, m_rd); end
    endtask

    task automatic test_overflow();
        logic [23:0] s[17];
        bus_write(2'd1, 32'h6);
        for (int i = 0; i < 17; i++) begin
            s[i] = 24'($urandom);
            bus_write(2'd0, {8'($urandom), s[i]});
        end
        bus_read(2'd1);
        checks++; if (read_data[31:16] !== 16'd16) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=16", read_data[31:16]); end
        checks++; if (read_data[2:1] !== 2'b11) begin errors++; $display("[TB] FAIL ovf_flags got=%b exp=11", read_data[2:1]); end
        checks++; if (read_data !== m_rd) begin errors++; $display("[TB] FAIL ovf_status got=%h exp=%h", read_data, m_rd); end
        sink_ready = 1'b1;
        bus_write(2'd1, 32'h1);
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++; if (sink_valid !== 1'b1 || sink_data !== s[i]) begin errors++; $display("[TB] FAIL drain_%0d got=%b/%h exp=1/%h", i, sink_valid, sink_data, s[i]); end
        end
        cycle();
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_end got=%b exp=0", sink_valid); end
    endtask

    task automatic test_hold();
        sink_ready = 1'b0;
        cycle();
        bus_write(2'd0, 32'h00AA_AAAA);
        bus_write(2'd0, 32'h0055_5555);
        bus_write(2'd1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (sink_valid !== 1'b1 || sink_data !== 24'hAAAAAA) begin errors++; $display("[TB] FAIL hold_%0d got=%b/%h exp=1/aaaaaa", i, sink_valid, sink_data); end
            cycle();
        end
        sink_ready = 1'b1;
        cycle();
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_accept got=%b exp=0", sink_valid); end
        cycle();
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_noload got=%b exp=0", sink_valid); end
        sink_ready = 1'b0;
        bus_read(2'd1);
        checks++; if (read_data[31:16] !== 16'd1 || read_data !== m_rd) begin errors++; $display("[TB] FAIL hold_status got=%h exp=%h", read_data, m_rd); end
        bus_write(2'd1, 32'h6);
    endtask

    task automatic test_underrun();
        sink_ready = 1'b0;
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h1);
        sink_ready = 1'b1;
        repeat (5) cycle();
        sink_ready = 1'b0;
        bus_read(2'd2);
        checks++; if (read_data !== 32'd5) begin errors++; $display("[TB] FAIL ucount_5 got=%0d exp=5", read_data); end
        bus_read(2'd1);
        checks++; if (read_data[3] !== 1'b1 || read_data !== m_rd) begin errors++; $display("[TB] FAIL underrun_flag got=%h exp=%h", read_data, m_rd); end
        bus_write(2'd1, 32'h5);
        bus_write(2'd2, 32'h0);
        bus_read(2'd1);
        checks++; if (read_data[3] !== 1'b0) begin errors++; $display("[TB] FAIL underrun_clear got=%b exp=0", read_data[3]); end
        bus_read(2'd2);
        checks++; if (read_data !== 32'd0) begin errors++; $display("[TB] FAIL ucount_clear got=%0d exp=0", read_data); end
        sink_ready = 1'b1;
        repeat (20) cycle();
        sink_ready = 1'b0;
        bus_read(2'd2);
        checks++; if (read_data !== 32'd15) begin errors++; $display("[TB] FAIL ucount_sat got=%0d exp=15", read_data); end
        sink_ready = 1'b1;
        bus_write(2'd2, 32'h0);
        bus_write(2'd1, 32'h5);
        sink_ready = 1'b0;
        bus_read(2'd2);
        checks++; if (read_data !== 32'd1) begin errors++; $display("[TB] FAIL ucount_clearwins got=%0d exp=1", read_data); end
        bus_read(2'd1);
        checks++; if (read_data[3] !== 1'b0) begin errors++; $display("[TB] FAIL flag_clearwins got=%b exp=0", read_data[3]); end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] wd;
        for (int n = 0; n < 500; n++) begin
            sink_ready = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 9);
            wd = $urandom;
            chipselect = 1'b1;
            read = 1'b0;
            write = 1'b0;
            address = 2'($urandom);
            writedata = wd;
            case (op)
                0, 1, 2, 3, 4: begin write = 1'b1; address = 2'd0; end
                5: begin
                    write = 1'b1;
                    address = 2'd1;
                    writedata[0] = ($urandom_range(0, 4) != 0);
                    writedata[1] = ($urandom_range(0, 7) == 0);
                    writedata[2] = ($urandom_range(0, 5) == 0);
                end
                6: begin write = 1'b1; address = 2'($urandom_range(2, 3)); end
                7: read = 1'b1;
                8: begin read = 1'b1; write = 1'b1; address = 2'($urandom_range(0, 2)); writedata[1] = 1'b0; end
                default: begin chipselect = 1'b0; write = 1'b1; read = 1'b1; end
            endcase
            cycle();
            chipselect = 1'b0;
            read = 1'b0;
            write = 1'b0;
            checks++; if (sink_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid_%0d got=%b exp=%b", n, sink_valid, m_valid); end
            checks++; if (read_data !== m_rd) begin errors++; $display("[TB] FAIL rnd_read_%0d got=%h exp=%h", n, read_data, m_rd); end
            if (m_valid) begin
                checks++; if (sink_data !== m_data) begin errors++; $display("[TB] FAIL rnd_data_%0d got=%h exp=%h", n, sink_data, m_data); end
            end
        end
    endtask

    task automatic test_flush();
        logic [23:0] first;
        logic [23:0] fresh;
        sink_ready = 1'b0;
        bus_write(2'd1, 32'h6);
        first = 24'($urandom);
        bus_write(2'd0, 32'(first));
        for (int i = 1; i < 8; i++) bus_write(2'd0, $urandom);
        bus_write(2'd1, 32'h1);
        cycle();
        checks++; if (sink_valid !== 1'b1 || sink_data !== first) begin errors++; $display("[TB] FAIL flush_pre got=%b/%h exp=1/%h", sink_valid, sink_data, first); end
        bus_write(2'd1, 32'h3);
        checks++; if (sink_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=0", sink_valid); end
        bus_read(2'd1);
        checks++; if (read_data !== 32'h0000_0011) begin errors++; $display("[TB] FAIL flush_status got=%h exp=00000011", read_data); end
        fresh = 24'($urandom);
        sink_ready = 1'b1;
        bus_write(2'd0, 32'(fresh));
        cycle();
        checks++; if (sink_valid !== 1'b1 || sink_data !== fresh) begin errors++; $display("[TB] FAIL flush_after got=%b/%h exp=1/%h", sink_valid, sink_data, fresh); end
        sink_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, $urandom);
        bus_read(2'd1);
        reset_n = 1'b0;
        cycle();
        checks++; if (sink_valid !== 1'b0 || sink_data !== 24'd0 || read_data !== 32'd0) begin errors++; $display("[TB] FAIL midreset got=%b/%h/%h exp=0/0/0", sink_valid, sink_data, read_data); end
        reset_n = 1'b1;
        bus_read(2'd1);
        checks++; if (read_data !== 32'h0000_0001) begin errors++; $display("[TB] FAIL midreset_status got=%h exp=00000001", read_data); end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        address    = 2'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        sink_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_hold();
        test_underrun();
        test_random();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_stream_writer.md
Name: audio_stream_writer

Overview:
- Host-to-stream counterpart of the FFT-side read interface: the CPU writes audio samples over the Avalon-MM slave bus, and the block presents them on a valid/ready streaming source toward the audio output path.
- Contains a DEPTH-entry sample FIFO plus one registered output stage.
- Exposes control, status, overflow/underrun flags and an underrun counter so the driver can pace its writes.

Parameters:
- DATA_SIZE, 24, sample width in bits (1..32).
- DEPTH, 16, FIFO storage entries; power of two, at least 2.
- CNT_W, 16, underrun counter width; counter saturates at its maximum value.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous active-low reset.
- chipselect  in  1  slave select.
- address  in  2  register index.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- read_data  out  32  registered read data.
- sink_valid  out  1  output sample valid.
- sink_data  out  DATA_SIZE  output sample.
- sink_ready  in  1  consumer ready.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - read_data=0, sink_valid=0, sink_data=0.
  - FIFO empty, level=0, enable=0.
  - overflow=0, underrun=0, underrun counter=0.
  - Reset wins over any bus access or handshake in the same cycle; a sample pending at the output is dropped.
- Register map (all accesses need chipselect=1):
  - addr 0 write, DATA: push writedata[DATA_SIZE-1:0] into the FIFO. If storage is full, drop the write and set overflow. A full FIFO rejects the push even when a pop happens in the same cycle. addr 0 read returns 0.
  - addr 1 write, CTRL:
    - bit0: enable (held).
    - bit1: flush, a one-cycle action. Empties the FIFO and clears sink_valid in the same edge, even mid-handshake.
    - bit2: clear overflow and underrun.
  - addr 1 read, STATUS:
    - [31:16] level, zero-extended.
    - bit4 enable, bit3 underrun, bit2 overflow, bit1 full, bit0 empty.
  - addr 2 write: clears the underrun counter. addr 2 read: counter value, zero-extended.
  - addr 3 read returns 0; addr 3 writes are ignored.
- Read latency: read_data updates on the edge where the read is sampled and is valid the following cycle. It holds its value when no read occurs.
- Write and read strobes in the same cycle: the write takes effect, and the read returns the pre-write register value.
- Output stage:
  - The output register loads the FIFO head when enable=1, the FIFO is non-empty, and the output is either empty (sink_valid=0) or being accepted this cycle (sink_valid & sink_ready).
  - A DATA write to an empty FIFO at edge N, with enable=1 and the output idle, gives sink_valid=1 after edge N+1.
  - Back-to-back transfers sustain one sample per cycle while sink_ready=1.
- Handshake:
  - Once sink_valid=1, sink_data stays stable and sink_valid stays high until sink_ready=1 is sampled.
  - Clearing enable does not retract a presented sample; only flush or reset retracts it.
- Level counts FIFO storage entries only (0..DEPTH) and excludes the output register.
  - full = (level==DEPTH); empty = (level==0).
  - Level changes by +1 on a push, -1 on a load into the output register, and 0 when both happen in one cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Underrun:
  - Each cycle with enable=1, sink_ready=1, sink_valid=0 and the FIFO empty sets the underrun flag and increments the counter.
  - The counter saturates at 2^CNT_W-1.
  - A flag or counter clear in the same cycle as an underrun event: the clear wins.
- Flush in the same cycle as a DATA push: flush first, then the push is accepted, so level=1 afterwards.

Test Plan:
- Reset then read STATUS: read_data=0x00000001 (empty=1, level=0, enable=0); sink_valid=0.
- Write CTRL=1, DATA=0x123456 with sink_ready=1: sink_valid=1 with sink_data=0x123456 after edge N+1; transfer completes; STATUS reads empty=1, enable=1.
- enable=0, write 17 samples (DEPTH=16): STATUS reads level=16, full=1, overflow=1; set enable=1 with sink_ready=1: exactly samples 1..16 appear in order on consecutive cycles.
- Hold sink_ready=0 while presenting 0xAAAAAA, toggle enable 1->0: sink_valid stays 1 and sink_data stays 0xAAAAAA until sink_ready=1; no further samples are loaded.
- enable=1, FIFO empty, sink_ready=1 for 5 cycles: addr 2 reads 5 and underrun=1; CTRL bit2 plus an addr 2 write: both clear; with CNT_W=4, 20 idle cycles give a counter of 15.
- Fill 8 samples, assert flush while sink_valid=1: next cycle sink_valid=0, level=0; subsequent samples are unaffected; drive reset_n=0 mid-stream: all outputs return to reset values.
